// File: rtl/fbw_pkg.sv
// Shared types and defaults for the frame buffer writer.
// Macro RGB565_TO_444_EN selects a 16-bit RGB565 pixel input instead of 12-bit RGB444.
package fbw_pkg;

  localparam int FRAME_PIXELS_DEF = 120000;
  localparam int ADDR_W_DEF       = 19;
  localparam int PIX_OUT_W        = 12;

`ifdef RGB565_TO_444_EN
  localparam int PIX_IN_W = 16;
`else
  localparam int PIX_IN_W = 12;
`endif

  typedef enum logic {
    WAIT_SOF = 1'b0,
    WRITE    = 1'b1
  } fbw_state_t;

endpackage

// File: rtl/fbw_pix_fmt.sv
// Combinational pixel-format conversion to RGB444.
// Macro RGB565_TO_444_EN keeps the top 4 bits of each RGB565 channel; otherwise pass-through.
module fbw_pix_fmt
  import fbw_pkg::*;
(
  input  logic [PIX_IN_W-1:0]  pix_in,
  output logic [PIX_OUT_W-1:0] pix_out
);

`ifdef RGB565_TO_444_EN
  logic unused_lsbs;
  assign unused_lsbs = ^{pix_in[11], pix_in[6:5], pix_in[0]};
  assign pix_out     = {pix_in[15:12], pix_in[10:7], pix_in[4:1]};
`else
  assign pix_out = pix_in;
`endif

endmodule

// File: rtl/frame_buf_writer.sv
// Writes a pixel stream into a double-buffered BRAM frame store and flips banks per frame.
// Macro RGB565_TO_444_EN widens s_data to 16-bit RGB565 (converted in fbw_pix_fmt).
module frame_buf_writer
  import fbw_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sof,
  input  logic [PIX_IN_W-1:0]  s_data,
  output logic                 bram_we,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [PIX_OUT_W-1:0] bram_din,
  output logic                 disp_bank,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long
);

  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_PIXELS);

  fbw_state_t           state, state_n;
  logic                 wr_bank, wr_bank_n, disp_bank_n;
  logic [ADDR_W-1:0]    pix_idx, pix_idx_n;
  logic                 long_armed, long_armed_n;
  logic                 accept;
  logic                 do_write;
  logic [ADDR_W-1:0]    wr_idx;
  logic                 we_d, done_d, err_short_d, err_long_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [PIX_OUT_W-1:0] din_d, pix_fmt;

  assign s_ready = rst_n;
  assign accept  = s_valid & s_ready;

  fbw_pix_fmt u_pix_fmt (
    .pix_in  (s_data),
    .pix_out (pix_fmt)
  );

  always_comb begin
    state_n      = state;
    wr_bank_n    = wr_bank;
    disp_bank_n  = disp_bank;
    pix_idx_n    = pix_idx;
    long_armed_n = long_armed;
    do_write     = 1'b0;
    wr_idx       = pix_idx;
    we_d         = 1'b0;
    addr_d       = bram_addr;
    din_d        = bram_din;
    done_d       = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;

    if (accept) begin
      unique case (state)
        WAIT_SOF: begin
          if (s_sof) begin
            do_write     = 1'b1;
            wr_idx       = '0;
            long_armed_n = 1'b0;
          end else if (long_armed) begin
            err_long_d   = 1'b1;
            long_armed_n = 1'b0;
          end
        end
        WRITE: begin
          do_write = 1'b1;
          // A premature sof restarts the current bank rather than flipping it.
          if (s_sof && (pix_idx != '0)) begin
            err_short_d = 1'b1;
            wr_idx      = '0;
          end
        end
        default: ;
      endcase
    end

    if (do_write) begin
      we_d   = 1'b1;
      addr_d = (wr_bank ? BANK1_BASE : '0) + wr_idx;
      din_d  = pix_fmt;
      if (wr_idx == IDX_LAST) begin
        done_d       = 1'b1;
        disp_bank_n  = wr_bank;
        wr_bank_n    = ~wr_bank;
        pix_idx_n    = '0;
        long_armed_n = 1'b1;
        state_n      = WAIT_SOF;
      end else begin
        pix_idx_n = wr_idx + 1'b1;
        state_n   = WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      wr_bank    <= 1'b1;
      disp_bank  <= 1'b0;
      pix_idx    <= '0;
      long_armed <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      state      <= state_n;
      wr_bank    <= wr_bank_n;
      disp_bank  <= disp_bank_n;
      pix_idx    <= pix_idx_n;
      long_armed <= long_armed_n;
      bram_we    <= we_d;
      bram_addr  <= addr_d;
      bram_din   <= din_d;
      frame_done <= done_d;
      err_short  <= err_short_d;
      err_long   <= err_long_d;
    end
  end

endmodule

// File: doc/frame_buf_writer.md
FRAME_BUF_WRITER -- requirements
Module: frame_buf_writer

Interface
REQ-001 Parameter FRAME_PIXELS, default 120000, pixels per frame; the write address wraps at FRAME_PIXELS-1.
REQ-002 Parameter ADDR_W, default 19, width of the BRAM write address.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  input  1  pixel/BRAM clock; all logic on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 s_valid  input  1  an upstream pixel is present.
REQ-007 s_ready  output  1  the block accepts a pixel this cycle.
REQ-008 s_sof  input  1  start of frame; qualified by s_valid and marks the first pixel.
REQ-009 s_data  input  12 (16 with RGB565_TO_444_EN)  pixel data.
REQ-010 bram_we  output  1  BRAM port-A write enable.
REQ-011 bram_addr  output  ADDR_W  BRAM port-A address.
REQ-012 bram_din  output  12  RGB444 write data.
REQ-013 disp_bank  output  1  bank holding the last complete frame, for the display-side reader.
REQ-014 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-015 err_short  output  1  one-cycle pulse when s_sof arrives before a frame is complete.
REQ-016 err_long  output  1  one-cycle pulse on the first surplus pixel after a frame is complete.

Function
REQ-017 A pixel SHALL be accepted when s_valid && s_ready; s_ready SHALL be 1 whenever rst_n is high and 0 while rst_n is low.
REQ-018 FSM states: WAIT_SOF and WRITE.
- WAIT_SOF: accepted pixels with s_sof=0 are dropped (no write); an accepted pixel with s_sof=1 is written at pixel index 0 and the FSM moves to WRITE.
- WRITE: each accepted pixel is written at the next index.
REQ-019 Write latency: bram_we, bram_addr and bram_din SHALL be registered and asserted exactly 1 cycle after acceptance; bram_we=0 on cycles with no accepted pixel to write.
REQ-020 bram_addr SHALL equal (wr_bank ? FRAME_PIXELS : 0) + pix_idx, where pix_idx is in 0..FRAME_PIXELS-1.
REQ-021 When the pixel at index FRAME_PIXELS-1 is accepted:
- frame_done pulses in the same cycle bram_we is asserted for that pixel;
- disp_bank takes wr_bank, wr_bank toggles, pix_idx returns to 0;
- the FSM moves to WAIT_SOF.
REQ-022 Short frame: s_sof accepted in WRITE with pix_idx≠0 SHALL pulse err_short, restart at index 0 of the same wr_bank, and write that pixel; disp_bank and wr_bank are unchanged.
REQ-023 Long frame: the first accepted non-sof pixel in WAIT_SOF after a frame_done SHALL pulse err_long once; that pixel and all later non-sof pixels are dropped until the next s_sof.
REQ-024 When s_sof coincides with the completion of the previous frame, completion is processed first; the sof pixel is the next accepted pixel and starts the new frame normally.
REQ-025 disp_bank SHALL never equal wr_bank while in WRITE, so writes never target the displayed bank.

Reset
REQ-026 While rst_n=0: s_ready=0, bram_we=0, bram_addr=0, bram_din=0, disp_bank=0, wr_bank=1, frame_done=0, err_short=0, err_long=0, FSM=WAIT_SOF.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; the first frame after reset is written to bank 1.

Configuration
REQ-028 Macro RGB565_TO_444_EN defined: s_data is 16-bit RGB565, and bram_din = {s_data[15:12], s_data[10:7], s_data[4:1]}.
REQ-029 Macro RGB565_TO_444_EN undefined: s_data is 12-bit and passes unchanged to bram_din.

Structure
REQ-030 Package fbw_pkg SHALL hold the FSM state typedef, FRAME_PIXELS_DEF=120000 and ADDR_W_DEF=19.
REQ-031 Sub-module fbw_pix_fmt SHALL hold the combinational pixel-format conversion; all other logic stays in one module.

Verification
REQ-032 Reset, then sof plus 120000 pixels with valid held high: addresses run 120000..239999, frame_done pulses once on the write to address 239999, then disp_bank=1.
REQ-033 Second full frame: addresses run 0..119999, then disp_bank=0.
REQ-034 Sof, 500 pixels, then sof: err_short pulses once, the next write goes to the bank base + 0, and disp_bank is unchanged.
REQ-035 Full frame followed by 3 extra pixels without sof: err_long pulses once and no bram_we is asserted for the 3 pixels.
REQ-036 Random s_valid gaps (30% idle) over a full frame: every bram_we is exactly 1 cycle after its acceptance and addresses are contiguous.
REQ-037 rst_n pulsed low at pixel 60000: all outputs take their reset values at once, and the next sof writes to address 120000.
